// File: rtl/dual_port_ram.sv
// Simple dual-port RAM: one synchronous write port, one registered read port with enable.
// Contents are not reset; the read register holds its value while read_en is low.
module dual_port_ram #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                  write_clock,
    input  logic                  write_en,
    input  logic [ADDR_WIDTH-1:0] write_addr,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  read_clock,
    input  logic                  read_en,
    input  logic [ADDR_WIDTH-1:0] read_addr,
    output logic [DATA_WIDTH-1:0] read_data
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge write_clock) begin
        if (write_en) begin
            mem_q[write_addr] <= write_data;
        end
    end

    always_ff @(posedge read_clock) begin
        if (read_en) begin
            read_data <= mem_q[read_addr];
        end
    end

endmodule

// File: rtl/sc_fifo.sv
// Single-clock FIFO on dual_port_ram with standard or first-word-fall-through output,
// registered status flags and sticky overflow/underflow.
module sc_fifo #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned FWFT       = 0,
    parameter int unsigned AF_LEVEL   = (1 << ADDR_WIDTH) - 1,
    parameter int unsigned AE_LEVEL   = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic [DATA_WIDTH-1:0] data_w,
    input  logic                  req_w,
    output logic                  full,
    output logic [DATA_WIDTH-1:0] data_r,
    input  logic                  req_r,
    output logic                  valid_r,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int unsigned      DEPTH   = 1 << ADDR_WIDTH;
    localparam int unsigned      PTR_W   = ADDR_WIDTH + 1;
    localparam logic [PTR_W-1:0] DEPTH_C = PTR_W'(DEPTH);
    localparam logic [PTR_W-1:0] AF_C    = PTR_W'(AF_LEVEL);
    localparam logic [PTR_W-1:0] AE_C    = PTR_W'(AE_LEVEL);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]      count_q, count_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic                  afull_q, afull_d;
    logic                  aempty_q, aempty_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;
    logic                  ram_vld_q, ram_vld_d;
    logic                  out_vld_q, out_vld_d;
    logic [DATA_WIDTH-1:0] data_r_q, data_r_d;
    logic [DATA_WIDTH-1:0] ram_rdata;
    logic                  push;
    logic                  pop;
    logic                  ram_read;
    logic                  out_load;
    logic                  ram_has_data;

    dual_port_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .write_clock (clk),
        .write_en    (push),
        .write_addr  (wr_ptr_q[ADDR_WIDTH-1:0]),
        .write_data  (data_w),
        .read_clock  (clk),
        .read_en     (ram_read),
        .read_addr   (rd_ptr_q[ADDR_WIDTH-1:0]),
        .read_data   (ram_rdata)
    );

    always_comb begin
        push         = req_w & ~full_q & ~clear;
        pop          = req_r & ~empty_q & ~clear;
        ram_has_data = (wr_ptr_q != rd_ptr_q);

        // ram_vld marks a word sitting in the RAM read register, not yet in data_r.
        if (FWFT != 0) begin
            out_load  = ram_vld_q & (~out_vld_q | pop) & ~clear;
            ram_read  = ram_has_data & (~ram_vld_q | out_load) & ~clear;
            out_vld_d = ~clear & (out_load | (out_vld_q & ~pop));
            ram_vld_d = ~clear & (ram_read | (ram_vld_q & ~out_load));
        end else begin
            out_load  = ram_vld_q & ~clear;
            ram_read  = pop;
            out_vld_d = out_load;
            ram_vld_d = ram_read;
        end

        wr_ptr_d = clear ? '0 : wr_ptr_q + PTR_W'(push);
        rd_ptr_d = clear ? '0 : rd_ptr_q + PTR_W'(ram_read);

        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (push && !pop) begin
            count_d = count_q + PTR_ONE;
        end else if (pop && !push) begin
            count_d = count_q - PTR_ONE;
        end

        full_d   = (count_d == DEPTH_C);
        empty_d  = (FWFT != 0) ? ~out_vld_d : (count_d == '0);
        afull_d  = (count_d >= AF_C);
        aempty_d = (count_d <= AE_C);

        ovf_d = ~clear & (ovf_q | (req_w & full_q));
        unf_d = ~clear & (unf_q | (req_r & empty_q));

        data_r_d = out_load ? ram_rdata : data_r_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
            afull_q   <= 1'b0;
            aempty_q  <= 1'b1;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
            ram_vld_q <= 1'b0;
            out_vld_q <= 1'b0;
            data_r_q  <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            full_q    <= full_d;
            empty_q   <= empty_d;
            afull_q   <= afull_d;
            aempty_q  <= aempty_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
            ram_vld_q <= ram_vld_d;
            out_vld_q <= out_vld_d;
            data_r_q  <= data_r_d;
        end
    end

    assign full         = full_q;
    assign empty        = empty_q;
    assign count        = count_q;
    assign almost_full  = afull_q;
    assign almost_empty = aempty_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;
    assign valid_r      = out_vld_q;
    assign data_r       = data_r_q;

endmodule

// File: tb/tb_sc_fifo.sv
// Directed bench for sc_fifo: a standard-read instance (suffix 0) and a FWFT instance
// (suffix 1), both DEPTH=4, AF_LEVEL=3, AE_LEVEL=1, sharing clock, reset and clear.
module tb_sc_fifo;

    logic       clk = 1'b0;
    logic       reset;
    logic       clear;
    logic [7:0] data_w0, data_w1;
    logic       req_w0, req_r0, req_w1, req_r1;
    logic       full0, valid_r0, empty0, af0, ae0, ovf0, unf0;
    logic       full1, valid_r1, empty1, af1, ae1, ovf1, unf1;
    logic [7:0] data_r0, data_r1;
    logic [2:0] count0, count1;
    int         total = 0;
    int         bad = 0;

    always #5 clk = ~clk;

    sc_fifo #(
        .DATA_WIDTH (8), .ADDR_WIDTH (2), .FWFT (0), .AF_LEVEL (3), .AE_LEVEL (1)
    ) dut0 (
        .clk (clk), .reset (reset), .clear (clear), .data_w (data_w0), .req_w (req_w0),
        .full (full0), .data_r (data_r0), .req_r (req_r0), .valid_r (valid_r0),
        .empty (empty0), .count (count0), .almost_full (af0), .almost_empty (ae0),
        .overflow (ovf0), .underflow (unf0)
    );

    sc_fifo #(
        .DATA_WIDTH (8), .ADDR_WIDTH (2), .FWFT (1), .AF_LEVEL (3), .AE_LEVEL (1)
    ) dut1 (
        .clk (clk), .reset (reset), .clear (clear), .data_w (data_w1), .req_w (req_w1),
        .full (full1), .data_r (data_r1), .req_r (req_r1), .valid_r (valid_r1),
        .empty (empty1), .count (count1), .almost_full (af1), .almost_empty (ae1),
        .overflow (ovf1), .underflow (unf1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write0(input logic [7:0] d);
        data_w0 = d; req_w0 = 1'b1; step(); req_w0 = 1'b0;
    endtask

    task automatic pop0();
        req_r0 = 1'b1; step(); req_r0 = 1'b0;
    endtask

    task automatic write1(input logic [7:0] d);
        data_w1 = d; req_w1 = 1'b1; step(); req_w1 = 1'b0;
    endtask

    task automatic test_reset();
        total++;
        if ({count0, empty0, full0, ae0, af0, valid_r0, ovf0, unf0} !== 10'b000_1010000) begin
            bad++;
            $display("FAIL reset0 got cnt=%0d e=%b f=%b ae=%b af=%b v=%b o=%b u=%b want 0/1/0/1/0/0/0/0",
                     count0, empty0, full0, ae0, af0, valid_r0, ovf0, unf0);
        end
        total++;
        if ({count1, empty1, full1, ae1, af1, valid_r1, ovf1, unf1} !== 10'b000_1010000) begin
            bad++;
            $display("FAIL reset1 got cnt=%0d e=%b f=%b ae=%b af=%b v=%b o=%b u=%b want 0/1/0/1/0/0/0/0",
                     count1, empty1, full1, ae1, af1, valid_r1, ovf1, unf1);
        end
        total++;
        if (data_r0 !== 8'h00 || data_r1 !== 8'h00) begin
            bad++; $display("FAIL reset_data got=%h/%h want=00/00", data_r0, data_r1);
        end
    endtask

    task automatic test_fill_drain();
        logic [7:0] exp [4];
        exp = '{8'h11, 8'h22, 8'h33, 8'h44};
        write0(8'h11);
        total++;
        if (count0 !== 3'd1 || ae0 !== 1'b1) begin
            bad++; $display("FAIL fill1 got cnt=%0d ae=%b want cnt=1 ae=1", count0, ae0);
        end
        write0(8'h22);
        total++;
        if (ae0 !== 1'b0) begin bad++; $display("FAIL fill2_ae got=%b want=0", ae0); end
        write0(8'h33);
        total++;
        if (af0 !== 1'b1 || full0 !== 1'b0) begin
            bad++; $display("FAIL fill3 got af=%b full=%b want af=1 full=0", af0, full0);
        end
        write0(8'h44);
        total++;
        if (full0 !== 1'b1 || count0 !== 3'd4 || af0 !== 1'b1) begin
            bad++;
            $display("FAIL fill4 got full=%b cnt=%0d af=%b want 1/4/1", full0, count0, af0);
        end
        write0(8'h55);
        total++;
        if (ovf0 !== 1'b1 || count0 !== 3'd4) begin
            bad++; $display("FAIL fill5_ovf got ovf=%b cnt=%0d want 1/4", ovf0, count0);
        end
        for (int i = 0; i < 4; i++) begin
            pop0();
            total++;
            if (valid_r0 !== 1'b0) begin
                bad++; $display("FAIL drain%0d_early_valid got=%b want=0", i, valid_r0);
            end
            step();
            total++;
            if (valid_r0 !== 1'b1 || data_r0 !== exp[i]) begin
                bad++;
                $display("FAIL drain%0d got v=%b d=%h want v=1 d=%h", i, valid_r0, data_r0, exp[i]);
            end
        end
        total++;
        if (empty0 !== 1'b1 || count0 !== 3'd0) begin
            bad++; $display("FAIL drain_empty got e=%b cnt=%0d want 1/0", empty0, count0);
        end
        step();
        total++;
        if (valid_r0 !== 1'b0 || data_r0 !== 8'h44) begin
            bad++; $display("FAIL drain_hold got v=%b d=%h want v=0 d=44", valid_r0, data_r0);
        end
    endtask

    task automatic test_wrap();
        logic [2:0] max_cnt;
        max_cnt = '0;
        clear = 1'b1; step(); clear = 1'b0;
        total++;
        if (ovf0 !== 1'b0) begin bad++; $display("FAIL wrap_clear_ovf got=%b want=0", ovf0); end
        for (int i = 0; i < 10; i++) begin
            write0(8'(i));
            if (count0 > max_cnt) max_cnt = count0;
            pop0();
            step();
            total++;
            if (valid_r0 !== 1'b1 || data_r0 !== 8'(i)) begin
                bad++; $display("FAIL wrap%0d got v=%b d=%h want v=1 d=%h", i, valid_r0, data_r0, 8'(i));
            end
        end
        total++;
        if (max_cnt !== 3'd1 || ovf0 !== 1'b0 || unf0 !== 1'b0 || empty0 !== 1'b1) begin
            bad++;
            $display("FAIL wrap_flags got max=%0d o=%b u=%b e=%b want 1/0/0/1",
                     max_cnt, ovf0, unf0, empty0);
        end
    endtask

    task automatic test_simultaneous();
        logic [7:0] exp [4];
        exp = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
        for (int i = 0; i < 4; i++) write0(exp[i]);
        data_w0 = 8'h66; req_w0 = 1'b1; req_r0 = 1'b1;
        step();
        req_w0 = 1'b0; req_r0 = 1'b0;
        total++;
        if (count0 !== 3'd3 || ovf0 !== 1'b1 || full0 !== 1'b0) begin
            bad++;
            $display("FAIL simfull got cnt=%0d ovf=%b full=%b want 3/1/0", count0, ovf0, full0);
        end
        step();
        total++;
        if (valid_r0 !== 1'b1 || data_r0 !== 8'hA1) begin
            bad++; $display("FAIL simfull_rd got v=%b d=%h want v=1 d=a1", valid_r0, data_r0);
        end
        for (int i = 1; i < 4; i++) begin
            pop0();
            step();
            total++;
            if (data_r0 !== exp[i]) begin
                bad++; $display("FAIL simfull_drain%0d got=%h want=%h", i, data_r0, exp[i]);
            end
        end
        total++;
        if (empty0 !== 1'b1 || count0 !== 3'd0) begin
            bad++; $display("FAIL simfull_dropped got e=%b cnt=%0d want 1/0", empty0, count0);
        end
        data_w0 = 8'h99; req_w0 = 1'b1; req_r0 = 1'b1;
        step();
        req_w0 = 1'b0; req_r0 = 1'b0;
        total++;
        if (count0 !== 3'd1 || unf0 !== 1'b1 || empty0 !== 1'b0) begin
            bad++;
            $display("FAIL simempty got cnt=%0d unf=%b e=%b want 1/1/0", count0, unf0, empty0);
        end
        step();
        total++;
        if (valid_r0 !== 1'b0) begin
            bad++; $display("FAIL simempty_noread got v=%b want=0", valid_r0);
        end
        pop0();
        step();
        total++;
        if (valid_r0 !== 1'b1 || data_r0 !== 8'h99) begin
            bad++; $display("FAIL simempty_rd got v=%b d=%h want v=1 d=99", valid_r0, data_r0);
        end
    endtask

    task automatic test_clear();
        write0(8'hE1); write0(8'hE2); write0(8'hE3);
        total++;
        if (count0 !== 3'd3 || unf0 !== 1'b1) begin
            bad++; $display("FAIL preclear got cnt=%0d unf=%b want 3/1", count0, unf0);
        end
        clear = 1'b1; data_w0 = 8'hEE; req_w0 = 1'b1;
        step();
        clear = 1'b0; req_w0 = 1'b0;
        total++;
        if ({count0, empty0, unf0, ovf0, af0, ae0, full0} !== 9'b000_100010) begin
            bad++;
            $display("FAIL clear got cnt=%0d e=%b u=%b o=%b af=%b ae=%b f=%b want 0/1/0/0/0/1/0",
                     count0, empty0, unf0, ovf0, af0, ae0, full0);
        end
        write0(8'h77);
        pop0();
        step();
        total++;
        if (valid_r0 !== 1'b1 || data_r0 !== 8'h77) begin
            bad++; $display("FAIL clear_rd got v=%b d=%h want v=1 d=77", valid_r0, data_r0);
        end
    endtask

    task automatic test_fwft_single();
        write1(8'hA5);
        total++;
        if (count1 !== 3'd1 || empty1 !== 1'b1) begin
            bad++; $display("FAIL fwft_t got cnt=%0d e=%b want 1/1", count1, empty1);
        end
        step();
        total++;
        if (empty1 !== 1'b1) begin bad++; $display("FAIL fwft_t1 got e=%b want=1", empty1); end
        step();
        total++;
        if (empty1 !== 1'b0 || valid_r1 !== 1'b1 || data_r1 !== 8'hA5) begin
            bad++;
            $display("FAIL fwft_t2 got e=%b v=%b d=%h want 0/1/a5", empty1, valid_r1, data_r1);
        end
        req_r1 = 1'b1; step(); req_r1 = 1'b0;
        total++;
        if (empty1 !== 1'b1 || valid_r1 !== 1'b0 || count1 !== 3'd0) begin
            bad++;
            $display("FAIL fwft_pop got e=%b v=%b cnt=%0d want 1/0/0", empty1, valid_r1, count1);
        end
    endtask

    task automatic test_fwft_burst();
        logic [7:0] exp [4];
        exp = '{8'hB1, 8'hB2, 8'hB3, 8'hB4};
        for (int i = 0; i < 4; i++) write1(exp[i]);
        total++;
        if (full1 !== 1'b1 || count1 !== 3'd4) begin
            bad++; $display("FAIL fwft_full got f=%b cnt=%0d want 1/4", full1, count1);
        end
        write1(8'hB5);
        total++;
        if (ovf1 !== 1'b1 || count1 !== 3'd4) begin
            bad++; $display("FAIL fwft_ovf got o=%b cnt=%0d want 1/4", ovf1, count1);
        end
        step(); step();
        total++;
        if (valid_r1 !== 1'b1 || data_r1 !== 8'hB1) begin
            bad++; $display("FAIL fwft_head got v=%b d=%h want v=1 d=b1", valid_r1, data_r1);
        end
        req_r1 = 1'b1;
        for (int i = 1; i < 4; i++) begin
            step();
            total++;
            if (valid_r1 !== 1'b1 || data_r1 !== exp[i]) begin
                bad++;
                $display("FAIL fwft_burst%0d got v=%b d=%h want v=1 d=%h", i, valid_r1, data_r1, exp[i]);
            end
        end
        step();
        req_r1 = 1'b0;
        total++;
        if (empty1 !== 1'b1 || count1 !== 3'd0 || unf1 !== 1'b0) begin
            bad++;
            $display("FAIL fwft_drained got e=%b cnt=%0d u=%b want 1/0/0", empty1, count1, unf1);
        end
    endtask

    task automatic test_async_reset();
        pop0();
        total++;
        if (unf0 !== 1'b1) begin bad++; $display("FAIL prerst_unf got=%b want=1", unf0); end
        write0(8'hC1); write0(8'hC2); write0(8'hC3);
        pop0();
        step();
        data_w0 = 8'hC4; req_w0 = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        total++;
        if ({count0, empty0, full0, ae0, af0, valid_r0, ovf0, unf0} !== 10'b000_1010000
            || data_r0 !== 8'h00) begin
            bad++;
            $display("FAIL async_rst got cnt=%0d e=%b f=%b ae=%b af=%b v=%b o=%b u=%b d=%h want 0/1/0/1/0/0/0/0/00",
                     count0, empty0, full0, ae0, af0, valid_r0, ovf0, unf0, data_r0);
        end
        req_w0 = 1'b0;
        step();
        reset = 1'b0;
        write0(8'h01); write0(8'h02);
        pop0();
        step();
        total++;
        if (valid_r0 !== 1'b1 || data_r0 !== 8'h01) begin
            bad++; $display("FAIL postrst1 got v=%b d=%h want v=1 d=01", valid_r0, data_r0);
        end
        pop0();
        step();
        total++;
        if (valid_r0 !== 1'b1 || data_r0 !== 8'h02) begin
            bad++; $display("FAIL postrst2 got v=%b d=%h want v=1 d=02", valid_r0, data_r0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; clear = 1'b0;
        data_w0 = '0; req_w0 = 1'b0; req_r0 = 1'b0;
        data_w1 = '0; req_w1 = 1'b0; req_r1 = 1'b0;
        step(); step();
        test_reset();
        reset = 1'b0;
        step();
        test_fill_drain();
        test_wrap();
        test_simultaneous();
        test_clear();
        test_fwft_single();
        test_fwft_burst();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sc_fifo.md
SC_FIFO -- requirements
Module: sc_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 8, word width in bits.
REQ-002 Parameter ADDR_WIDTH, default 8, log2 of depth; DEPTH = 2^ADDR_WIDTH words, all usable.
REQ-003 Parameter FWFT, default 0; 0 = standard read, 1 = first-word-fall-through.
REQ-004 Parameter AF_LEVEL, default DEPTH-1; almost_full asserts at count >= AF_LEVEL.
REQ-005 Parameter AE_LEVEL, default 1; almost_empty asserts at count <= AE_LEVEL.
REQ-006 Ports, one per line:
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- clear  in  1  synchronous flush
- data_w  in  DATA_WIDTH  write data
- req_w  in  1  write request
- full  out  1  no space
- data_r  out  DATA_WIDTH  read data
- req_r  in  1  read request (pop)
- valid_r  out  1  standard mode: data_r valid this cycle; FWFT: equals !empty
- empty  out  1  no readable word
- count  out  ADDR_WIDTH+1  words held, 0..DEPTH
- almost_full  out  1  count >= AF_LEVEL
- almost_empty  out  1  count <= AE_LEVEL
- overflow  out  1  sticky: write attempted while full
- underflow  out  1  sticky: read attempted while empty

Function
REQ-007 Write accepted when req_w=1 and full=0; a write with full=1 is dropped regardless of req_r in the same cycle.
REQ-008 Read accepted when req_r=1 and empty=0; a read with empty=1 is ignored regardless of req_w in the same cycle.
REQ-009 Pointers are ADDR_WIDTH+1 bits; the extra MSB distinguishes full from empty; both wrap modulo 2^(ADDR_WIDTH+1).
REQ-010 count, full, empty, almost_full and almost_empty are registered and reflect all accepted operations one cycle after the accepting edge.
REQ-011 Simultaneous accepted write and read leave count unchanged.
REQ-012 Standard mode: read accepted at edge t gives data_r and valid_r=1 after edge t+1; valid_r=0 otherwise; data_r holds its last value while valid_r=0.
REQ-013 FWFT mode: head word is presented on data_r whenever empty=0; the output register counts toward count; a word written into an empty FIFO at edge t gives empty=0 after edge t+2; a pop of the head loads the next word with no bubble when RAM holds data.
REQ-014 FWFT mode: total capacity is DEPTH (RAM plus output register); full asserts at count = DEPTH.
REQ-015 Write-then-read ordering is strict FIFO across pointer wrap-around.
REQ-016 overflow/underflow set on the first offending request and hold until reset or clear.
REQ-017 clear=1 at an edge zeroes pointers, count and sticky flags, drops in-cycle requests, invalidates the FWFT output register, and leaves RAM contents undefined-but-unread.

Reset
REQ-018 reset=1 forces immediately: pointers 0, count 0, empty 1, full 0, almost_empty 1, almost_full 0, valid_r 0, overflow 0, underflow 0, data_r 0.
REQ-019 Reset asserted mid-operation discards all stored words; the first write after deassertion is the first word read.

Structure
REQ-020 No shared package; DEPTH and pointer widths are localparams derived from parameters.
REQ-021 Storage is the existing dual_port_ram sub-module with read_clock and write_clock both tied to clk; no other sub-module.

Verification (DATA_WIDTH=8, ADDR_WIDTH=2, DEPTH=4, AF_LEVEL=3, AE_LEVEL=1)
REQ-022 FWFT=0: write 0x11,0x22,0x33,0x44 -> full=1, count=4, almost_full=1; fifth write 0x55 -> dropped, overflow=1; four reads -> 0x11..0x44, each one cycle after req_r, then empty=1.
REQ-023 FWFT=0: 10 write/read pairs with values 0x00..0x09 across wrap -> output order 0x00..0x09, count max 1, no flags set.
REQ-024 FWFT=1: single write 0xA5 into empty FIFO at edge t -> empty=0 and data_r=0xA5 after edge t+2 with no req_r; pop -> empty=1 next cycle.
REQ-025 Full FIFO with simultaneous req_w(0x66) and req_r -> read accepted, write dropped, count=3, overflow=1; empty FIFO with simultaneous req_w and req_r -> write accepted, read ignored, underflow=1, count=1.
REQ-026 Three words stored, clear=1 one cycle -> count=0, empty=1, flags 0; then write 0x77, read -> 0x77.
REQ-027 Reset pulsed asynchronously mid-burst between edges -> outputs reach REQ-018 values before next edge; subsequent 0x01,0x02 write/read -> 0x01,0x02.
